// File: rtl/fetch_pkg.sv
// Shared widths, HALT opcode and the {addr, instr} entry type for the fetch unit.
package fetch_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 16;
   localparam logic [3:0]  OPC_HALT = 4'hF;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: InstrMem read port, redirect input and decode-side valid/ready output.
interface instr_fetch_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output halted
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  halted
   );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO of fetch entries; entry 0 is always the head.
module fetch_fifo2
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop_eff;

   assign pop_eff = pop_i && (cnt_q != 2'd0);

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = 2'd0;
      end else begin
         case ({push_i, pop_eff})
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = push_data_i;
               else               e1_d = push_data_i;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               // Full FIFO: shift and refill the tail in the same edge.
               if (cnt_q == 2'd2) begin
                  e0_d = e1_q;
                  e1_d = push_data_i;
               end else begin
                  e0_d = push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign head_o  = e0_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues InstrMem reads, buffers {pc, instr} for decode, handles redirect.
// Optional HALT-opcode stop is enabled by defining IFETCH_HALT_EN.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);

   logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, issue_addr;
   logic              pend_q, pend_d, halted_q, halted_d;
   logic              redirect, pop, push, credit, issue;
   logic [1:0]        count;
   logic [2:0]        occ;
   fetch_entry_t      head, cap;

   assign redirect   = bus.redirect_valid;
   assign pop        = bus.out_valid && bus.out_ready;
   assign issue_addr = redirect ? bus.redirect_pc : pc_q;

   // Slots committed next cycle: buffered plus in-flight, minus the one leaving now.
   assign occ    = {1'b0, count} + {2'b00, pend_q};
   assign credit = (occ - {2'b00, pop}) < 3'd2;
   assign issue  = redirect || (!halted_q && credit);
   assign push   = pend_q && !redirect && !halted_q;
   assign cap    = '{addr: pend_pc_q, instr: bus.imem_rdata};

   always_comb begin
      pc_d      = issue ? issue_addr + ADDR_W'(1) : pc_q;
      pend_d    = issue;
      pend_pc_d = issue ? issue_addr : pend_pc_q;
   end

`ifdef IFETCH_HALT_EN
   always_comb begin
      halted_d = halted_q;
      if (redirect)                                             halted_d = 1'b0;
      else if (push && (bus.imem_rdata[DATA_W-1 -: 4] == OPC_HALT)) halted_d = 1'b1;
   end
`else
   assign halted_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         halted_q  <= halted_d;
      end
   end

   fetch_fifo2 u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (cap),
      .pop_i       (pop),
      .flush_i     (redirect),
      .count_o     (count),
      .head_o      (head)
   );

   assign bus.imem_addr = issue_addr;
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_pc    = head.addr;
   assign bus.out_instr = head.instr;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: InstrMem model plus scoreboard of expected {pc, instr} deliveries.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [1024];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   fetch_entry_t      sb_q [$];
   int                n_tests = 0;
   int                n_fail  = 0;
   logic              s_valid, s_ready, s_halted;
   logic [ADDR_W-1:0] s_pc, s_addr, held_pc;
   logic [DATA_W-1:0] s_instr, held_instr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, score any handshake, return just after the posedge.
   task automatic cycle();
      fetch_entry_t e;
      @(negedge clk);
      s_valid  = bus.out_valid;
      s_ready  = bus.out_ready;
      s_pc     = bus.out_pc;
      s_instr  = bus.out_instr;
      s_addr   = bus.imem_addr;
      s_halted = bus.halted;
      if (s_valid === 1'b1 && s_ready) begin
         n_tests++;
         assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed pc=%0d expected no delivery", s_pc);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", 32'(s_pc), 32'(e.addr));
            chk("sb_instr", 32'(s_instr), 32'(e.instr));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] pc, input int n);
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < n; i++) begin
         a = pc + ADDR_W'(i);
         sb_q.push_back('{addr: a, instr: mem[a]});
      end
   endtask

   // Redirect with decode stalled, then expect n words from target onward.
   task automatic do_redirect(input logic [ADDR_W-1:0] target, input int n);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      bus.out_ready      = 1'b0;
      cycle();
      sb_q.delete();
      push_exp(target, n);
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      cycle();
      chk("redir_gap_valid", 32'(s_valid), 32'd0);
      cycle();
      chk("redir_first_valid", 32'(s_valid), 32'd1);
      chk("redir_first_pc", 32'(s_pc), 32'(target));
      for (int i = 1; i < n; i++) begin
         cycle();
         chk("redir_stream_valid", 32'(s_valid), 32'd1);
      end
      bus.out_ready = 1'b0;
      chk("redir_drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
      mem[10]  = 16'hABCD;
      mem[100] = 16'hFFFF;

      rst                = 1'b1;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      cycle();
      cycle();
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_pc", 32'(s_pc), 32'd0);
      chk("rst_instr", 32'(s_instr), 32'd0);
      chk("rst_halted", 32'(s_halted), 32'd0);
      chk("rst_addr", 32'(s_addr), 32'd0);

      // Sequential fetch from RESET_PC.
      push_exp('0, 20);
      rst = 1'b0;
      cycle();
      chk("c0_valid", 32'(s_valid), 32'd0);
      cycle();
      chk("c1_valid", 32'(s_valid), 32'd0);
      cycle();
      chk("c2_valid", 32'(s_valid), 32'd1);
      chk("c2_pc", 32'(s_pc), 32'd0);
      chk("c2_instr", 32'(s_instr), 32'h1000);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("seq_valid", 32'(s_valid), 32'd1);
      end

      // Backpressure for 5 cycles: head stays put.
      bus.out_ready = 1'b0;
      cycle();
      held_pc    = s_pc;
      held_instr = s_instr;
      chk("bp_head_pc", 32'(s_pc), 32'd6);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("bp_valid", 32'(s_valid), 32'd1);
         chk("bp_pc_stable", 32'(s_pc), 32'(held_pc));
         chk("bp_instr_stable", 32'(s_instr), 32'(held_instr));
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         cycle();
         chk("bp_resume_valid", 32'(s_valid), 32'd1);
      end
      bus.out_ready = 1'b0;
      chk("seq_drain", 32'(sb_q.size()), 32'd0);

      // Fill the buffer, then redirect to 10.
      for (int i = 0; i < 3; i++) cycle();
      chk("fill_valid", 32'(s_valid), 32'd1);
      chk("fill_pc", 32'(s_pc), 32'd20);
      do_redirect(10'd10, 6);

      do_redirect(10'd1022, 4);

`ifdef IFETCH_HALT_EN
      do_redirect(10'd98, 3);
      chk("halt_set", 32'(s_halted), 32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("halt_no_valid", 32'(s_valid), 32'd0);
         chk("halt_held", 32'(s_halted), 32'd1);
      end
      bus.out_ready = 1'b0;
      do_redirect(10'd0, 3);
      chk("halt_cleared", 32'(s_halted), 32'd0);
`else
      chk("halted_tied", 32'(s_halted), 32'd0);
`endif

      // Reset while streaming, with decode just stalled and a read in flight.
      do_redirect(10'd30, 4);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      sb_q.delete();
      push_exp('0, 4);
      bus.out_ready = 1'b1;
      cycle();
      chk("rst2_valid", 32'(s_valid), 32'd0);
      chk("rst2_addr", 32'(s_addr), 32'd0);
      chk("rst2_pc", 32'(s_pc), 32'd0);
      cycle();
      chk("rst2_c1_valid", 32'(s_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rst2_stream_valid", 32'(s_valid), 32'd1);
      end
      bus.out_ready = 1'b0;
      chk("rst2_drain", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
